// File: rtl/risc4_pkg.sv
// ============================================================================
// Module   : risc4_pkg
// Brief    : Shared R-type encoding constants and the alu -> funct mapping
//            used by both the issue-side encoder and the CONTROL decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc4_pkg;

    localparam logic [3:0] OPC_RTYPE = 4'b1100;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0001;
    localparam logic [3:0] FUNCT_OR  = 4'b0010;
    localparam logic [3:0] FUNCT_AND = 4'b0011;
    localparam logic [3:0] FUNCT_SLL = 4'b0100;
    localparam logic [3:0] FUNCT_SRL = 4'b0101;
    localparam logic [3:0] FUNCT_MUL = 4'b0110;
    localparam logic [3:0] FUNCT_XOR = 4'b0111;

    // Every 3-bit code is legal, so funct[3] never gets set.
    function automatic logic [3:0] alu_to_funct(input logic [2:0] alu);
        logic [3:0] funct;
        case (alu)
            ALU_ADD: funct = FUNCT_ADD;
            ALU_SUB: funct = FUNCT_SUB;
            ALU_OR:  funct = FUNCT_OR;
            ALU_AND: funct = FUNCT_AND;
            ALU_SLL: funct = FUNCT_SLL;
            ALU_SRL: funct = FUNCT_SRL;
            ALU_MUL: funct = FUNCT_MUL;
            default: funct = FUNCT_XOR;
        endcase
        return funct;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ============================================================================
// Module   : instr_fifo
// Brief    : Generic DEPTH x WIDTH synchronous FIFO with flush and occupancy
//            count; no input-to-output bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign in_ready  = (r_count != C_DEPTH);
    assign out_valid = (r_count != '0);
    assign out_count = r_count;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Pointers are exactly AW bits, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes ALU requests into R-type words and buffers them in a FIFO.
//            Define INSTR_ENC_STATS_EN to add the 16-bit issue_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import risc4_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int REG_AW = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_alu,
    input  logic [REG_AW-1:0]         in_rd,
    input  logic [REG_AW-1:0]         in_rs1,
    input  logic [REG_AW-1:0]         in_rs2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [8+3*REG_AW-1:0]     out_instr,
    output logic [$clog2(DEPTH):0]    out_count
`ifdef INSTR_ENC_STATS_EN
    ,
    output logic [15:0]               issue_count
`endif
);

    localparam int IW = 8 + 3 * REG_AW;

    logic [IW-1:0] w_instr;

    assign w_instr = {OPC_RTYPE, alu_to_funct(in_alu), in_rd, in_rs1, in_rs2};

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_instr),
        .out_count (out_count)
    );

`ifdef INSTR_ENC_STATS_EN
    logic        w_pop;
    logic [15:0] r_issue_count;

    // A pop coinciding with flush is discarded, so it is not counted.
    assign w_pop = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_count <= '0;
        end else if (w_pop) begin
            r_issue_count <= r_issue_count + 16'd1;
        end
    end

    assign issue_count = r_issue_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Directed self-checking bench for instr_encoder (DEPTH=4, REG_AW=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int REG_AW = 3;
    localparam int IW     = 17;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_alu;
    logic [2:0]    in_rd;
    logic [2:0]    in_rs1;
    logic [2:0]    in_rs2;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [2:0]    out_count;
`ifdef INSTR_ENC_STATS_EN
    logic [15:0]   issue_count;
`endif

    instr_encoder #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu      (in_alu),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_count   (out_count)
`ifdef INSTR_ENC_STATS_EN
        ,
        .issue_count (issue_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]    funct_tab [8];
    logic [IW-1:0] w_q [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        in_valid = 1'b1;
        in_alu   = a;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
    endtask

    function automatic logic [IW-1:0] enc(input logic [2:0] a, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        return {4'b1100, funct_tab[a], rd, rs1, rs2};
    endfunction

    // Inverse of the table: what the CONTROL decoder recovers from a word.
    function automatic logic [2:0] ctrl_alu(input logic [IW-1:0] w);
        logic [2:0] a;
        a = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (funct_tab[i] == w[12:9]) a = 3'(i);
        end
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        funct_tab[3'b010] = 4'b0000;
        funct_tab[3'b100] = 4'b0001;
        funct_tab[3'b001] = 4'b0010;
        funct_tab[3'b000] = 4'b0011;
        funct_tab[3'b011] = 4'b0100;
        funct_tab[3'b101] = 4'b0101;
        funct_tab[3'b110] = 4'b0110;
        funct_tab[3'b111] = 4'b0111;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_alu = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(out_count), 32'd0);
        check("rst_instr",     32'(out_instr), 32'd0);
`ifdef INSTR_ENC_STATS_EN
        check("rst_issue",     32'(issue_count), 32'd0);
`endif

        // Single SUB request, one-cycle latency, no bypass
        out_ready = 1'b1;
        drive(3'b100, 3'd1, 3'd2, 3'd3);
        check("sub_no_bypass", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("sub_instr", 32'(out_instr), 32'({4'b1100, 4'b0001, 3'd1, 3'd2, 3'd3}));
        check("sub_valid", 32'(out_valid), 32'd1);
        check("sub_count", 32'(out_count), 32'd1);
        tick();
        check("sub_popped", 32'(out_valid), 32'd0);

        // All eight codes back-to-back with continuous drain
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 3'(i), 3'(7 - i), 3'(i) ^ 3'd3);
            tick();
            check("b2b_instr", 32'(out_instr), 32'(enc(3'(i), 3'(i), 3'(7 - i), 3'(i) ^ 3'd3)));
            check("b2b_ctrl_alu", 32'(ctrl_alu(out_instr)), 32'(i));
            check("b2b_regwrite", 32'(out_instr[16:13] == 4'b1100), 32'd1);
            check("b2b_count", 32'(out_count), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("b2b_drained", 32'(out_count), 32'd0);

        // Fill to full with a blocked consumer; fifth request is held
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w_q[k] = enc(3'(k), 3'(k), 3'(k + 1), 3'd2);
            drive(3'(k), 3'(k), 3'(k + 1), 3'd2);
            if (k < 4) check("fill_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        check("full_count",    32'(out_count), 32'd4);
        check("full_in_ready", 32'(in_ready),  32'd0);
        check("full_head",     32'(out_instr), 32'(w_q[0]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pop_count", 32'(out_count), 32'd3);
        check("full_pop_ready", 32'(in_ready),  32'd1);
        check("full_pop_head",  32'(out_instr), 32'(w_q[1]));
        tick();
        in_valid = 1'b0;
        check("held_accepted", 32'(out_count), 32'd4);
        out_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            check("full_order", 32'(out_instr), 32'(w_q[j]));
            tick();
        end
        check("full_drained", 32'(out_count), 32'd0);

        // Flush a full FIFO while a push and pop are offered
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(3'(k), 3'd5, 3'd6, 3'd7);
            tick();
        end
        in_valid = 1'b0;
        check("pre_flush_count", 32'(out_count), 32'd4);
        flush = 1'b1; out_ready = 1'b1;
        drive(3'b111, 3'd1, 3'd1, 3'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(out_count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_instr", 32'(out_instr), 32'd0);
        check("flush_ready", 32'(in_ready),  32'd1);
`ifdef INSTR_ENC_STATS_EN
        check("flush_issue", 32'(issue_count), 32'd14);
`endif
        tick();
        check("flush_push_dropped", 32'(out_count), 32'd0);

        // Steady push+pop across pointer wrap
        out_ready = 1'b1;
        drive(3'b010, 3'd0, 3'd7, 3'd1);
        tick();
        for (int c = 1; c <= 10; c++) begin
            drive(3'(c), 3'(c), ~3'(c), 3'(c + 1));
            tick();
            check("wrap_count", 32'(out_count), 32'd1);
            check("wrap_instr", 32'(out_instr), 32'(enc(3'(c), 3'(c), ~3'(c), 3'(c + 1))));
        end
        in_valid = 1'b0;
        tick();
        check("wrap_drained", 32'(out_count), 32'd0);
`ifdef INSTR_ENC_STATS_EN
        check("wrap_issue", 32'(issue_count), 32'd25);
`endif

        // Reset mid-stream drops buffered words
        out_ready = 1'b0;
        drive(3'b001, 3'd2, 3'd2, 3'd2);
        tick();
        tick();
        in_valid = 1'b0;
        check("mid_count", 32'(out_count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count", 32'(out_count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
`ifdef INSTR_ENC_STATS_EN
        check("mid_rst_issue", 32'(issue_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
